// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// The master side is the datapath: it reports stage status and receives
// the register enables, flushes and statistics. The slave side is the
// hazard sequencer itself.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Stage status reported by the datapath
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteRegister;
    logic             EX_BranchTaken;
    logic             MEM_MemAccess;
    logic             DMEM_Ready;

    // Pipeline controls produced by the sequencer
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             MEMWB_Bubble;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_WriteRegister,
               EX_BranchTaken, MEM_MemAccess, DMEM_Ready,
        input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
               IFID_Flush, IDEX_Flush, MEMWB_Bubble, MemTimeout,
               StallCount, FlushCount
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_WriteRegister,
               EX_BranchTaken, MEM_MemAccess, DMEM_Ready,
        output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
               IFID_Flush, IDEX_Flush, MEMWB_Bubble, MemTimeout,
               StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline. Resolves load-use stalls,
// taken-branch flushes from EX and multi-cycle data-memory waits, and
// drives every pipeline-register enable/flush/bubble. A branch seen while
// memory is frozen is remembered and applied once, on the release cycle.
// Keeps saturating stall/flush counters and a sticky dmem timeout state.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic             pending_flush_reg;
    logic [CNT_W-1:0] timer_reg;

    logic memwait;
    logic loaduse;
    logic br;

    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
    logic mem_timeout;

    // Hazard detection terms, purely combinational on the current stage status
    always_comb begin
        memwait = hz.MEM_MemAccess && !hz.DMEM_Ready;
        loaduse = hz.EX_MemRead && (hz.EX_WriteRegister != 5'd0) &&
                  ((hz.EX_WriteRegister == hz.ID_rs) ||
                   (hz.ID_UsesRt && (hz.EX_WriteRegister == hz.ID_rt)));
        br      = hz.EX_BranchTaken || pending_flush_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: enter wait on a stalled dmem access, leave on ready, trap on timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RUN: begin
                if (memwait) begin
                    state_next = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (hz.DMEM_Ready) begin
                    state_next = S_RUN;
                end else if (timer_reg == TIMEOUT_L) begin
                    state_next = S_ERROR;
                end
            end
            S_ERROR: begin
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // Mealy controls: freeze beats branch flush, which beats load-use stall
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;
        // While reset is asserted the pipeline sees plain RUN defaults
        if (rst_n) begin
            case (state_reg)
                S_RUN, S_MEM_WAIT: begin
                    // In RUN memwait covers the not-ready case; in MEM_WAIT
                    // any not-ready cycle keeps the pipeline frozen
                    if ((state_reg == S_RUN) ? memwait : !hz.DMEM_Ready) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                    end else if (br) begin
                        // PC takes the branch target; younger instructions die,
                        // so a coincident load-use no longer matters
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (loaduse) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                S_ERROR: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    mem_timeout  = 1'b1;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    // Wait timer and deferred-branch latch; the flush is consumed on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg         <= '0;
            pending_flush_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (memwait) begin
                        timer_reg         <= CNT_ONE;
                        pending_flush_reg <= hz.EX_BranchTaken;
                    end
                end
                S_MEM_WAIT: begin
                    if (!hz.DMEM_Ready) begin
                        timer_reg         <= timer_reg + CNT_ONE;
                        pending_flush_reg <= pending_flush_reg | hz.EX_BranchTaken;
                    end else begin
                        timer_reg         <= '0;
                        pending_flush_reg <= 1'b0;
                    end
                end
                default: begin
                    timer_reg         <= timer_reg;
                    pending_flush_reg <= pending_flush_reg;
                end
            endcase
        end
    end

    // Index 0 counts stall cycles (PC held), index 1 counts flush cycles
    logic [1:0] stat_inc;
    assign stat_inc = {ifid_flush, !pc_write};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : stat_gen
            logic [CNT_W-1:0] cnt_reg;

            // Saturating event counter, sticks at all-ones
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign hz.PC_Write     = pc_write;
    assign hz.IFID_Write   = ifid_write;
    assign hz.IDEX_Write   = idex_write;
    assign hz.EXMEM_Write  = exmem_write;
    assign hz.IFID_Flush   = ifid_flush;
    assign hz.IDEX_Flush   = idex_flush;
    assign hz.MEMWB_Bubble = memwb_bubble;
    assign hz.MemTimeout   = mem_timeout;
    assign hz.StallCount   = stat_gen[0].cnt_reg;
    assign hz.FlushCount   = stat_gen[1].cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// The driver applies one directed vector per cycle just after the rising
// edge and queues its hand-computed expectation; the monitor pops one
// expectation per falling edge and compares controls and counters.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Control vector bit order:
    // {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
    //  IFID_Flush, IDEX_Flush, MEMWB_Bubble, MemTimeout}
    localparam logic [7:0] C_DEF = 8'b1111_0000;
    localparam logic [7:0] C_LU  = 8'b0011_0100;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_FRZ = 8'b0000_0010;
    localparam logic [7:0] C_ERR = 8'b0000_0011;

    typedef struct {
        logic [7:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    pipeline_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifc.slave)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue what must be seen this cycle
    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic usesrt, input logic memrd, input logic [4:0] wr,
                         input logic brt, input logic acc, input logic rdy,
                         input logic [7:0] ec, input int es, input int ef,
                         input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                = !rst;
        ifc.ID_rs            = rs;
        ifc.ID_rt            = rt;
        ifc.ID_UsesRt        = usesrt;
        ifc.EX_MemRead       = memrd;
        ifc.EX_WriteRegister = wr;
        ifc.EX_BranchTaken   = brt;
        ifc.MEM_MemAccess    = acc;
        ifc.DMEM_Ready       = rdy;
        e.ctrl  = ec;
        e.stall = CNT_W'(es);
        e.flush = CNT_W'(ef);
        e.name  = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each cycle presents one response
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({ifc.PC_Write, ifc.IFID_Write, ifc.IDEX_Write, ifc.EXMEM_Write,
                 ifc.IFID_Flush, ifc.IDEX_Flush, ifc.MEMWB_Bubble, ifc.MemTimeout} !== mon_e.ctrl)
                $display("FAIL %s ctrl got %b want %b", mon_e.name,
                         {ifc.PC_Write, ifc.IFID_Write, ifc.IDEX_Write, ifc.EXMEM_Write,
                          ifc.IFID_Flush, ifc.IDEX_Flush, ifc.MEMWB_Bubble, ifc.MemTimeout},
                         mon_e.ctrl);
            else
                passes++;
            checks++;
            if (ifc.StallCount !== mon_e.stall)
                $display("FAIL %s StallCount got %0d want %0d", mon_e.name, ifc.StallCount, mon_e.stall);
            else
                passes++;
            checks++;
            if (ifc.FlushCount !== mon_e.flush)
                $display("FAIL %s FlushCount got %0d want %0d", mon_e.name, ifc.FlushCount, mon_e.flush);
            else
                passes++;
            $display("txn %-16s ctrl=%b stall=%0d flush=%0d", mon_e.name,
                     {ifc.PC_Write, ifc.IFID_Write, ifc.IDEX_Write, ifc.EXMEM_Write,
                      ifc.IFID_Flush, ifc.IDEX_Flush, ifc.MEMWB_Bubble, ifc.MemTimeout},
                     ifc.StallCount, ifc.FlushCount);
        end
    end

    initial begin
        rst_n                = 1'b0;
        ifc.ID_rs            = '0;
        ifc.ID_rt            = '0;
        ifc.ID_UsesRt        = 1'b0;
        ifc.EX_MemRead       = 1'b0;
        ifc.EX_WriteRegister = '0;
        ifc.EX_BranchTaken   = 1'b0;
        ifc.MEM_MemAccess    = 1'b0;
        ifc.DMEM_Ready       = 1'b0;

        //    rst rs  rt  ut mr wr  br ac rd  ctrl   stl flu  name
        // Reset overrides a live load-use pattern
        drive(1, 5,  0,  0, 1, 5,  0, 0, 0, C_DEF,  0, 0, "reset");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  0, 0, "idle0");
        // Load-use on rs, then rt ignored without UsesRt, then rt with UsesRt
        drive(0, 5,  0,  0, 1, 5,  0, 0, 0, C_LU,   0, 0, "lu_rs");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  1, 0, "after_lu");
        drive(0, 0,  5,  0, 1, 5,  0, 0, 0, C_DEF,  1, 0, "rt_no_uses");
        drive(0, 0,  5,  1, 1, 5,  0, 0, 0, C_LU,   1, 0, "lu_rt");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  2, 0, "idle1");
        // Destination r0 never stalls
        drive(0, 0,  0,  1, 1, 0,  0, 0, 0, C_DEF,  2, 0, "wr_r0");
        // Branch wins over load-use
        drive(0, 5,  0,  0, 1, 5,  1, 0, 0, C_BR,   2, 0, "br_over_lu");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  2, 1, "idle2");
        // Memory wait of 3 not-ready cycles, then release
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ,  2, 1, "wait3_c1");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ,  3, 1, "wait3_c2");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ,  4, 1, "wait3_c3");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 1, C_DEF,  5, 1, "wait3_rel");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  5, 1, "idle3");
        // Branch pulse at start of a 2-cycle wait flushes only on release
        drive(0, 0,  0,  0, 0, 0,  1, 1, 0, C_FRZ,  5, 1, "defer_c1");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ,  6, 1, "defer_c2");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 1, C_BR,   7, 1, "defer_rel");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  7, 2, "idle4");
        // Branch held across two wait cycles still flushes once
        drive(0, 0,  0,  0, 0, 0,  1, 1, 0, C_FRZ,  7, 2, "brhold_c1");
        drive(0, 0,  0,  0, 0, 0,  1, 1, 0, C_FRZ,  8, 2, "brhold_c2");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 1, C_BR,   9, 2, "brhold_rel");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  9, 3, "idle5");
        // Load-use on the release cycle still stalls
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ,  9, 3, "relu_c1");
        drive(0, 5,  0,  0, 1, 5,  0, 1, 1, C_LU,  10, 3, "relu_rel");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF, 11, 3, "idle6");
        // Timeout: RUN entry plus 4 MEM_WAIT cycles, then ERROR
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ, 11, 3, "to_run");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ, 12, 3, "to_t1");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ, 13, 3, "to_t2");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ, 14, 3, "to_t3");
        drive(0, 0,  0,  0, 0, 0,  0, 1, 0, C_FRZ, 15, 3, "to_t4");
        // ERROR is sticky even when dmem becomes ready
        drive(0, 0,  0,  0, 0, 0,  0, 1, 1, C_ERR, 15, 3, "err_rdy");
        drive(0, 0,  0,  0, 0, 0,  1, 0, 0, C_ERR, 15, 3, "err_hold");
        // Reset from ERROR restores defaults and clears counters
        drive(1, 0,  0,  0, 0, 0,  0, 1, 0, C_DEF,  0, 0, "err_reset");
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF,  0, 0, "post_reset");
        // Saturation: 20 load-use cycles, StallCount sticks at 15
        for (int i = 0; i < 20; i++) begin
            drive(0, 5, 0, 0, 1, 5, 0, 0, 0, C_LU, (i > 15) ? 15 : i, 0, "sat_lu");
        end
        drive(0, 0,  0,  0, 0, 0,  0, 0, 0, C_DEF, 15, 0, "sat_end");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
